// File: rtl/simon_req_scheduler.sv
// simon_req_scheduler: round-robin front end that time-shares one simon_96_96
// core between NREQ requesters. Each operation is: grant, launch, wait for
// done (with a watchdog), then hold the response until it is accepted.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Requesters hold req_valid and their data until they see their
// req_ready bit. resp_valid is held, with resp_ct/resp_id/resp_err unchanged,
// until the edge on which resp_ready is also high.
module simon_req_scheduler #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*96-1:0] req_pt,
  input  logic [NREQ*96-1:0] req_key,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [95:0]       resp_ct,
  output logic [IDW-1:0]    resp_id,
  output logic              resp_err,
  output logic              core_rst,
  output logic              core_en,
  output logic [95:0]       core_pt,
  output logic [95:0]       core_key,
  input  logic [95:0]       core_ct,
  input  logic              core_done
);

  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic [WDW-1:0] wdog;
  logic           wdog_fire;
  logic           core_rst_q;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  // Walking offsets from high to low lets the smallest offset win.
  always_comb begin : grant_sel
    int             idx;
    logic [IDW-1:0] cand;
    idx       = 0;
    cand      = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx  = (int'(rr_ptr) + i) % NREQ;
      cand = IDW'(idx);
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // One-hot accept, only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_any && !rst) req_ready[grant_idx] = 1'b1;
  end

  // Watchdog expires on the TIMEOUT-th WAIT cycle if done has not arrived.
  assign wdog_fire = (state == S_WAIT) && !core_done && (wdog == WDW'(TIMEOUT - 1));

  assign core_en    = (state == S_LAUNCH);
  assign resp_valid = (state == S_RESP);
  assign core_rst   = core_rst_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; done is deliberately ignored in LAUNCH because the
  // core may still be showing done from the previous operation.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (grant_any) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (core_done || wdog_fire) state_nxt = S_RESP;
      S_RESP:   if (resp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: grant latching, watchdog counting, response capture, core reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      core_pt    <= '0;
      core_key   <= '0;
      resp_ct    <= '0;
      resp_id    <= '0;
      resp_err   <= 1'b0;
      wdog       <= '0;
      core_rst_q <= 1'b1;
    end else begin
      core_rst_q <= wdog_fire;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            core_pt  <= req_pt[grant_idx*96 +: 96];
            core_key <= req_key[grant_idx*96 +: 96];
            resp_id  <= grant_idx;
            rr_ptr   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
          end
        end
        S_LAUNCH: wdog <= '0;
        S_WAIT: begin
          wdog <= wdog + WDW'(1);
          if (core_done) begin
            resp_ct  <= core_ct;
            resp_err <= 1'b0;
          end else if (wdog_fire) begin
            resp_ct  <= '0;
            resp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
